// File: rtl/axis_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : axis_txn_sequencer
// Purpose  : Sequences one fixed-length AXI-Stream request (H2C -> probe)
//            followed by one fixed-length response (probe -> C2H). Only the
//            handshake and tlast are handled here; tdata/tkeep are wired
//            around this block. Length mismatches and a silent probe are
//            reported through sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module axis_txn_sequencer #(
    parameter int VIP2DUT_WORDS_NUM = 16,
    parameter int DUT2VIP_WORDS_NUM = 16,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic       s_axis_aclk,
    input  logic       s_axis_aresetn,
    input  logic       h2c_tvalid,
    input  logic       h2c_tlast,
    output logic       h2c_tready,
    output logic       prb_s_tvalid,
    input  logic       prb_s_tready,
    input  logic       prb_m_tvalid,
    input  logic       prb_m_tlast,
    output logic       prb_m_tready,
    output logic       c2h_tvalid,
    input  logic       c2h_tready,
    output logic [1:0] seq_state,
    output logic       err_len,
    output logic       err_timeout,
    input  logic       err_clr
);

    // Counter widths hold 0..max; a width of 1 keeps the watchdog legal when disabled.
    localparam int c_REQ_W = $clog2(VIP2DUT_WORDS_NUM + 1);
    localparam int c_RSP_W = $clog2(DUT2VIP_WORDS_NUM + 1);
    localparam int c_WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [c_REQ_W-1:0] c_REQ_LAST = c_REQ_W'(VIP2DUT_WORDS_NUM);
    localparam logic [c_RSP_W-1:0] c_RSP_LAST = c_RSP_W'(DUT2VIP_WORDS_NUM);
    localparam logic [c_WD_W-1:0]  c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] c_ST_REQ   = 2'd0;
    localparam logic [1:0] c_ST_RSP   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [c_REQ_W-1:0] r_req_cnt;
    logic [c_RSP_W-1:0] r_rsp_cnt;
    logic [c_WD_W-1:0]  r_wd_cnt;
    logic               r_err_len;
    logic               r_err_timeout;

    logic [1:0]         w_state_nxt;
    logic [c_REQ_W-1:0] w_req_cnt_nxt;
    logic [c_RSP_W-1:0] w_rsp_cnt_nxt;
    logic [c_WD_W-1:0]  w_wd_cnt_nxt;
    logic               w_set_len;
    logic               w_set_timeout;

    // Incremented counts never exceed the maximum, so they fit the counter width.
    logic [c_REQ_W-1:0] w_req_inc;
    logic [c_RSP_W-1:0] w_rsp_inc;
    logic [c_WD_W-1:0]  w_wd_inc;
    logic               w_rsp_done_len;

    assign w_req_inc      = r_req_cnt + c_REQ_W'(1);
    assign w_rsp_inc      = r_rsp_cnt + c_RSP_W'(1);
    assign w_wd_inc       = r_wd_cnt + c_WD_W'(1);
    assign w_rsp_done_len = (w_rsp_inc == c_RSP_LAST);

    assign seq_state   = r_state;
    assign err_len     = r_err_len;
    assign err_timeout = r_err_timeout;

    // Next-state, counter updates and zero-latency handshake routing per state.
    always_comb begin
        w_state_nxt   = r_state;
        w_req_cnt_nxt = r_req_cnt;
        w_rsp_cnt_nxt = r_rsp_cnt;
        w_wd_cnt_nxt  = r_wd_cnt;
        w_set_len     = 1'b0;
        w_set_timeout = 1'b0;
        h2c_tready    = 1'b0;
        prb_s_tvalid  = 1'b0;
        prb_m_tready  = 1'b0;
        c2h_tvalid    = 1'b0;

        case (r_state)
            c_ST_REQ: begin
                prb_s_tvalid = h2c_tvalid;
                h2c_tready   = prb_s_tready;
                if (h2c_tvalid && prb_s_tready) begin
                    if (w_req_inc == c_REQ_LAST) begin
                        w_req_cnt_nxt = '0;
                        if (h2c_tlast) begin
                            w_state_nxt = c_ST_RSP;
                        end else begin
                            // Packet is too long: swallow the rest up to its tlast.
                            w_set_len   = 1'b1;
                            w_state_nxt = c_ST_DRAIN;
                        end
                    end else if (h2c_tlast) begin
                        // Short packet: flag it and expect no response.
                        w_set_len     = 1'b1;
                        w_req_cnt_nxt = '0;
                    end else begin
                        w_req_cnt_nxt = w_req_inc;
                    end
                end
            end

            c_ST_DRAIN: begin
                h2c_tready = 1'b1;
                if (h2c_tvalid && h2c_tlast) begin
                    w_state_nxt = c_ST_REQ;
                end
            end

            c_ST_RSP: begin
                c2h_tvalid   = prb_m_tvalid;
                prb_m_tready = c2h_tready;
                if (prb_m_tvalid && c2h_tready) begin
                    // A handshake always beats a coincident watchdog expiry.
                    w_wd_cnt_nxt = '0;
                    if (prb_m_tlast || w_rsp_done_len) begin
                        w_state_nxt   = c_ST_REQ;
                        w_rsp_cnt_nxt = '0;
                        w_set_len     = prb_m_tlast ^ w_rsp_done_len;
                    end else begin
                        w_rsp_cnt_nxt = w_rsp_inc;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (w_wd_inc == c_WD_LIMIT) begin
                        w_set_timeout = 1'b1;
                        w_state_nxt   = c_ST_REQ;
                        w_req_cnt_nxt = '0;
                        w_rsp_cnt_nxt = '0;
                        w_wd_cnt_nxt  = '0;
                    end else begin
                        w_wd_cnt_nxt = w_wd_inc;
                    end
                end
            end

            default: begin
                w_state_nxt   = c_ST_REQ;
                w_req_cnt_nxt = '0;
                w_rsp_cnt_nxt = '0;
                w_wd_cnt_nxt  = '0;
            end
        endcase

        // Handshake outputs are held low for as long as reset is asserted.
        if (!s_axis_aresetn) begin
            h2c_tready   = 1'b0;
            prb_s_tvalid = 1'b0;
            prb_m_tready = 1'b0;
            c2h_tvalid   = 1'b0;
        end
    end

    // State, counters and sticky error flags; a new error wins over err_clr.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            r_state       <= c_ST_REQ;
            r_req_cnt     <= '0;
            r_rsp_cnt     <= '0;
            r_wd_cnt      <= '0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_cnt <= w_req_cnt_nxt;
            r_rsp_cnt <= w_rsp_cnt_nxt;
            r_wd_cnt  <= w_wd_cnt_nxt;

            if (w_set_len) begin
                r_err_len <= 1'b1;
            end else if (err_clr) begin
                r_err_len <= 1'b0;
            end

            if (w_set_timeout) begin
                r_err_timeout <= 1'b1;
            end else if (err_clr) begin
                r_err_timeout <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_txn_sequencer
// Purpose  : Self-checking bench for axis_txn_sequencer: table of packet
//            scenarios plus hand-written corner sequences (blocking during
//            the response, watchdog expiry, handshake-vs-expiry, reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_txn_sequencer;

    localparam int c_TO = 8;

    logic       s_axis_aclk    = 1'b0;
    logic       s_axis_aresetn = 1'b0;
    logic       h2c_tvalid     = 1'b0;
    logic       h2c_tlast      = 1'b0;
    logic       h2c_tready;
    logic       prb_s_tvalid;
    logic       prb_s_tready   = 1'b0;
    logic       prb_m_tvalid   = 1'b0;
    logic       prb_m_tlast    = 1'b0;
    logic       prb_m_tready;
    logic       c2h_tvalid;
    logic       c2h_tready     = 1'b0;
    logic [1:0] seq_state;
    logic       err_len;
    logic       err_timeout;
    logic       err_clr        = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int c2h_total = 0;

    bit q_fwd[$];
    bit q_c2h[$];

    typedef struct {
        int req_n;     // beats offered on H2C
        int req_last;  // beat carrying tlast (0 = none)
        int n_fwd;     // beats expected on the probe slave port
        int st_req;    // seq_state right after the request
        int rsp_n;     // response beats driven (0 = no response)
        int rsp_last;  // response beat carrying tlast (0 = none)
        int exp_err;   // err_len expected at the end
        int bp;        // random backpressure
    } vec_t;

    vec_t vecs[8];

    axis_txn_sequencer #(
        .VIP2DUT_WORDS_NUM(16),
        .DUT2VIP_WORDS_NUM(16),
        .TIMEOUT_CYCLES   (c_TO)
    ) u_dut (
        .s_axis_aclk   (s_axis_aclk),
        .s_axis_aresetn(s_axis_aresetn),
        .h2c_tvalid    (h2c_tvalid),
        .h2c_tlast     (h2c_tlast),
        .h2c_tready    (h2c_tready),
        .prb_s_tvalid  (prb_s_tvalid),
        .prb_s_tready  (prb_s_tready),
        .prb_m_tvalid  (prb_m_tvalid),
        .prb_m_tlast   (prb_m_tlast),
        .prb_m_tready  (prb_m_tready),
        .c2h_tvalid    (c2h_tvalid),
        .c2h_tready    (c2h_tready),
        .seq_state     (seq_state),
        .err_len       (err_len),
        .err_timeout   (err_timeout),
        .err_clr       (err_clr)
    );

    always #5 s_axis_aclk = ~s_axis_aclk;

    // Independent count of every C2H handshake seen on the wire.
    always @(negedge s_axis_aclk) begin
        if (c2h_tvalid && c2h_tready) c2h_total <= c2h_total + 1;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive an H2C packet; each beat's forwarding expectation is queued at drive time.
    task automatic send_pkt(input int n, input int last_at, input int n_fwd, input int bp);
        int guard;
        bit exp;
        for (int i = 1; i <= n; i++) begin
            h2c_tvalid   = 1'b1;
            h2c_tlast    = (i == last_at);
            prb_s_tready = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            q_fwd.push_back(i <= n_fwd);
            guard = 0;
            @(negedge s_axis_aclk);
            while (!h2c_tready && guard < 32) begin
                @(posedge s_axis_aclk); #1;
                prb_s_tready = 1'b1;
                @(negedge s_axis_aclk);
                guard++;
            end
            exp = q_fwd.pop_front();
            if (!h2c_tready) check("h2c_accept_timeout", 0, 1);
            else check("req_forward", int'(prb_s_tvalid && prb_s_tready), int'(exp));
            @(posedge s_axis_aclk); #1;
        end
        h2c_tvalid   = 1'b0;
        h2c_tlast    = 1'b0;
        prb_s_tready = 1'b1;
    endtask

    // Drive a probe response; every beat must pass to C2H while H2C stays blocked.
    task automatic send_rsp(input int n, input int last_at, input int bp, output int cnt);
        int guard;
        bit exp;
        cnt = 0;
        for (int i = 1; i <= n; i++) begin
            prb_m_tvalid = 1'b1;
            prb_m_tlast  = (i == last_at);
            c2h_tready   = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            q_c2h.push_back(1'b1);
            guard = 0;
            @(negedge s_axis_aclk);
            while (!prb_m_tready && guard < 32) begin
                @(posedge s_axis_aclk); #1;
                c2h_tready = 1'b1;
                @(negedge s_axis_aclk);
                guard++;
            end
            exp = q_c2h.pop_front();
            if (!prb_m_tready) begin
                check("rsp_accept_timeout", 0, 1);
            end else begin
                check("c2h_pass", int'(c2h_tvalid && c2h_tready), int'(exp));
                check("h2c_blocked_in_rsp", int'(h2c_tready), 0);
                cnt++;
            end
            @(posedge s_axis_aclk); #1;
        end
        prb_m_tvalid = 1'b0;
        prb_m_tlast  = 1'b0;
        c2h_tready   = 1'b1;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(posedge s_axis_aclk); #1;
        err_clr = 1'b0;
        check("err_len_cleared", int'(err_len), 0);
        check("err_timeout_cleared", int'(err_timeout), 0);
    endtask

    initial begin
        int cnt;
        int c0;

        vecs[0] = '{16, 16, 16, 1, 16, 16, 0, 0};
        vecs[1] = '{16, 16, 16, 1, 16, 16, 0, 1};
        vecs[2] = '{ 5,  5,  5, 0,  0,  0, 1, 0};
        vecs[3] = '{ 1,  1,  1, 0,  0,  0, 1, 0};
        vecs[4] = '{20, 20, 16, 0,  0,  0, 1, 0};
        vecs[5] = '{17, 17, 16, 0,  0,  0, 1, 1};
        vecs[6] = '{16, 16, 16, 1, 10, 10, 1, 0};
        vecs[7] = '{16, 16, 16, 1, 16,  0, 1, 0};

        // Reset: outputs forced low even with every input asserted.
        repeat (3) @(posedge s_axis_aclk);
        #1;
        h2c_tvalid = 1'b1; prb_s_tready = 1'b1; prb_m_tvalid = 1'b1; c2h_tready = 1'b1;
        @(negedge s_axis_aclk);
        check("rst_h2c_tready", int'(h2c_tready), 0);
        check("rst_prb_s_tvalid", int'(prb_s_tvalid), 0);
        check("rst_prb_m_tready", int'(prb_m_tready), 0);
        check("rst_c2h_tvalid", int'(c2h_tvalid), 0);
        check("rst_state", int'(seq_state), 0);
        check("rst_err_len", int'(err_len), 0);
        check("rst_err_timeout", int'(err_timeout), 0);
        @(posedge s_axis_aclk); #1;
        s_axis_aresetn = 1'b1;
        h2c_tvalid = 1'b0; prb_m_tvalid = 1'b0;

        // Table-driven packet scenarios.
        for (int v = 0; v < 8; v++) begin
            c0 = c2h_total;
            send_pkt(vecs[v].req_n, vecs[v].req_last, vecs[v].n_fwd, vecs[v].bp);
            check($sformatf("v%0d_state_after_req", v), int'(seq_state), vecs[v].st_req);
            if (vecs[v].rsp_n > 0) begin
                send_rsp(vecs[v].rsp_n, vecs[v].rsp_last, vecs[v].bp, cnt);
                check($sformatf("v%0d_rsp_beats", v), cnt, vecs[v].rsp_n);
            end
            check($sformatf("v%0d_state_end", v), int'(seq_state), 0);
            check($sformatf("v%0d_err_len", v), int'(err_len), vecs[v].exp_err);
            check($sformatf("v%0d_err_timeout", v), int'(err_timeout), 0);
            check($sformatf("v%0d_c2h_total", v), c2h_total - c0, vecs[v].rsp_n);
            clear_errors();
        end

        // Second request offered during the response stays blocked until it ends.
        send_pkt(16, 16, 16, 0);
        check("blk_state_rsp", int'(seq_state), 1);
        h2c_tvalid = 1'b1; h2c_tlast = 1'b0;
        send_rsp(16, 16, 0, cnt);
        h2c_tvalid = 1'b1;
        check("blk_state_req", int'(seq_state), 0);
        check("blk_h2c_ready_after", int'(h2c_tready), 1);
        send_pkt(16, 16, 16, 0);
        send_rsp(16, 16, 0, cnt);
        check("blk_second_done", int'(seq_state), 0);
        check("blk_err_len", int'(err_len), 0);

        // Silent probe: timeout exactly 8 cycles after RSP entry; set beats clear.
        send_pkt(16, 16, 16, 0);
        check("to_state_rsp", int'(seq_state), 1);
        for (int k = 1; k <= c_TO; k++) begin
            if (k == c_TO) err_clr = 1'b1;
            @(posedge s_axis_aclk); #1;
            err_clr = 1'b0;
            check($sformatf("to_flag_c%0d", k), int'(err_timeout), (k == c_TO) ? 1 : 0);
            check($sformatf("to_state_c%0d", k), int'(seq_state), (k == c_TO) ? 0 : 1);
        end
        clear_errors();

        // Response handshake on the expiry cycle keeps the watchdog quiet.
        send_pkt(16, 16, 16, 0);
        repeat (c_TO - 1) @(posedge s_axis_aclk);
        #1;
        check("hs_pre_state", int'(seq_state), 1);
        check("hs_pre_flag", int'(err_timeout), 0);
        send_rsp(16, 16, 0, cnt);
        check("hs_err_timeout", int'(err_timeout), 0);
        check("hs_state_end", int'(seq_state), 0);
        check("hs_err_len", int'(err_len), 0);

        // Reset after response beat 7 abandons the transaction without errors.
        send_pkt(16, 16, 16, 0);
        send_rsp(7, 0, 0, cnt);
        check("mid_state_rsp", int'(seq_state), 1);
        h2c_tvalid = 1'b1; prb_m_tvalid = 1'b1; c2h_tready = 1'b1; prb_s_tready = 1'b1;
        s_axis_aresetn = 1'b0;
        @(negedge s_axis_aclk);
        check("mid_rst_h2c_tready", int'(h2c_tready), 0);
        check("mid_rst_prb_s_tvalid", int'(prb_s_tvalid), 0);
        check("mid_rst_prb_m_tready", int'(prb_m_tready), 0);
        check("mid_rst_c2h_tvalid", int'(c2h_tvalid), 0);
        @(posedge s_axis_aclk); #1;
        check("mid_rst_state", int'(seq_state), 0);
        check("mid_rst_err_len", int'(err_len), 0);
        check("mid_rst_err_timeout", int'(err_timeout), 0);
        s_axis_aresetn = 1'b1;
        h2c_tvalid = 1'b0; prb_m_tvalid = 1'b0;
        c0 = c2h_total;
        send_pkt(16, 16, 16, 0);
        check("post_rst_state_rsp", int'(seq_state), 1);
        send_rsp(16, 16, 0, cnt);
        check("post_rst_state_end", int'(seq_state), 0);
        check("post_rst_c2h_total", c2h_total - c0, 16);
        check("post_rst_err_len", int'(err_len), 0);
        check("post_rst_err_timeout", int'(err_timeout), 0);

        repeat (2) @(posedge s_axis_aclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
